// File: rtl/morse_pkg.sv
// morse_pkg: event codes, code width and classifier FSM state type
package morse_pkg;
    localparam int CODE_W = 3;
    localparam logic [CODE_W-1:0] CODE_NONE    = 3'd0;
    localparam logic [CODE_W-1:0] CODE_DOT     = 3'd1;
    localparam logic [CODE_W-1:0] CODE_DASH    = 3'd2;
    localparam logic [CODE_W-1:0] CODE_INVALID = 3'd3;
    localparam logic [CODE_W-1:0] CODE_LETTER  = 3'd4;
    localparam logic [CODE_W-1:0] CODE_WORD    = 3'd5;
    typedef enum logic [1:0] {ST_IDLE, ST_PRESS, ST_GAP} state_t;
endpackage

// File: rtl/key_debouncer.sv
// key_debouncer: 2-flop synchroniser plus stable-sample debounce (clk, rst_n, key_raw -> key_db)
module key_debouncer #(
    parameter int DEBOUNCE = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    output logic key_db
);
    localparam int DW = $clog2(DEBOUNCE + 1);
    logic [1:0]    sync;
    logic [DW-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync   <= '0;
            cnt    <= '0;
            key_db <= 1'b0;
        end else begin
            sync <= {sync[0], key_raw};
            if (sync[1] == key_db) cnt <= '0;
            else if (cnt == DW'(DEBOUNCE - 1)) begin
                cnt    <= '0;
                key_db <= ~key_db;
            end else cnt <= cnt + DW'(1);
        end
    end
endmodule

// File: rtl/morse_key_classifier.sv
// morse_key_classifier: debounced key press/gap timing classified into Morse events on a valid/ready port
// ports: clk, rst_n (async low), key_raw, enable, out_valid/out_ready/out_code/out_len, ovf/ovf_clr
module morse_key_classifier
    import morse_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int DEBOUNCE   = 4,
    parameter int DOT_MAX    = 10,
    parameter int DASH_MIN   = 30,
    parameter int LETTER_GAP = 30,
    parameter int WORD_GAP   = 70
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_raw,
    input  logic              enable,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] out_code,
    output logic [CNT_W-1:0]  out_len,
    output logic              ovf,
    input  logic              ovf_clr
);
    if (!(DOT_MAX < DASH_MIN && LETTER_GAP < WORD_GAP && DEBOUNCE >= 1 &&
          longint'(WORD_GAP) < (longint'(1) << CNT_W) && longint'(DASH_MIN) < (longint'(1) << CNT_W)))
    begin : g_bad_params
        $error("morse_key_classifier: inconsistent thresholds");
    end

    localparam logic [CNT_W-1:0] SAT    = '1;
    localparam logic [CNT_W-1:0] L_DOT  = CNT_W'(DOT_MAX);
    localparam logic [CNT_W-1:0] L_DASH = CNT_W'(DASH_MIN);
    localparam logic [CNT_W-1:0] L_LET  = CNT_W'(LETTER_GAP);
    localparam logic [CNT_W-1:0] L_WORD = CNT_W'(WORD_GAP);

    logic              key_db;
    state_t            state;
    logic [CNT_W-1:0]  cnt, cnt_inc;
    logic              ev;
    logic [CODE_W-1:0] ev_code;

    key_debouncer #(.DEBOUNCE(DEBOUNCE)) u_deb (
        .clk(clk), .rst_n(rst_n), .key_raw(key_raw), .key_db(key_db)
    );

    assign cnt_inc = (cnt == SAT) ? cnt : cnt + CNT_W'(1);

    // press events fire on the falling key_db sample; gap events fire when the gap count hits a threshold
    always_comb begin
        ev = enable && !key_db &&
             (state == ST_PRESS || (state == ST_GAP && (cnt == L_LET || cnt == L_WORD)));
        ev_code = (state == ST_PRESS) ?
                  ((cnt <= L_DOT) ? CODE_DOT : (cnt >= L_DASH) ? CODE_DASH : CODE_INVALID) :
                  ((cnt == L_WORD) ? CODE_WORD : CODE_LETTER);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_code  <= CODE_NONE;
            out_len   <= '0;
            ovf       <= 1'b0;
        end else begin
            if (!enable) begin
                state <= ST_IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    ST_IDLE: if (key_db) begin
                        state <= ST_PRESS;
                        cnt   <= CNT_W'(1);
                    end
                    ST_PRESS: if (key_db) cnt <= cnt_inc;
                    else begin
                        state <= ST_GAP;
                        cnt   <= CNT_W'(1);
                    end
                    ST_GAP: if (key_db) begin
                        state <= ST_PRESS;
                        cnt   <= CNT_W'(1);
                    end else if (cnt == L_WORD) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else cnt <= cnt_inc;
                    default: begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
            // single-entry slot: a new event while the held one is stalled is dropped
            if (ev && out_valid && !out_ready) ovf <= 1'b1;
            else if (ovf_clr) ovf <= 1'b0;
            if (ev && (!out_valid || out_ready)) begin
                out_valid <= 1'b1;
                out_code  <= ev_code;
                out_len   <= cnt;
            end else if (out_ready) out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_morse_key_classifier.sv
// tb_morse_key_classifier: directed scoreboard bench for morse_key_classifier
module tb_morse_key_classifier;
    import morse_pkg::*;

    logic clk = 1'b0, rst_n = 1'b0, key_raw = 1'b0, key_b = 1'b0;
    logic enable = 1'b1, out_ready = 1'b1, ovf_clr = 1'b0;
    logic out_valid, ovf, b_valid, b_ovf;
    logic [2:0] out_code, b_code;
    logic [15:0] out_len;
    logic [5:0] b_len;
    int tests = 0, fails = 0;

    typedef struct packed {logic [2:0] code; logic [15:0] len;} ev_t;
    ev_t q[$];
    ev_t qb[$];

    always #5 clk = ~clk;

    morse_key_classifier dut (
        .clk(clk), .rst_n(rst_n), .key_raw(key_raw), .enable(enable),
        .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
        .out_len(out_len), .ovf(ovf), .ovf_clr(ovf_clr)
    );

    morse_key_classifier #(.CNT_W(6), .WORD_GAP(60)) dut_b (
        .clk(clk), .rst_n(rst_n), .key_raw(key_b), .enable(1'b1),
        .out_valid(b_valid), .out_ready(1'b1), .out_code(b_code),
        .out_len(b_len), .ovf(b_ovf), .ovf_clr(1'b0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input int n);
        key_raw = 1'b1;
        cyc(n);
        key_raw = 1'b0;
    endtask

    task automatic push(input logic [2:0] c, input logic [15:0] l);
        ev_t e;
        e.code = c;
        e.len  = l;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) chk("spurious_event", 32'(out_code), 32'd0);
            else begin
                e = q.pop_front();
                chk("event_code", 32'(out_code), 32'(e.code));
                chk("event_len", 32'(out_len), 32'(e.len));
            end
        end
        if (rst_n && b_valid) begin
            if (qb.size() == 0) chk("b_spurious_event", 32'(b_code), 32'd0);
            else begin
                e = qb.pop_front();
                chk("b_event_code", 32'(b_code), 32'(e.code));
                chk("b_event_len", 32'(b_len), 32'(e.len));
            end
        end
    end

    initial begin
        ev_t eb;
        cyc(3);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_code", 32'(out_code), 0);
        chk("rst_len", 32'(out_len), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_b_valid", 32'(b_valid), 0);
        rst_n = 1'b1;
        cyc(2);
        press(3);
        cyc(30);
        chk("glitch_no_event", 32'(out_valid), 0);
        chk("glitch_key_db", 32'(dut.key_db), 0);

        push(CODE_DOT, 16'd8);
        push(CODE_LETTER, 16'd30);
        push(CODE_WORD, 16'd70);
        press(8);
        cyc(100);
        chk("dot_gaps_drained", q.size(), 0);

        push(CODE_INVALID, 16'd20);
        push(CODE_DASH, 16'd40);
        push(CODE_LETTER, 16'd30);
        push(CODE_WORD, 16'd70);
        press(20);
        cyc(10);
        press(40);
        cyc(110);
        chk("inv_dash_drained", q.size(), 0);

        out_ready = 1'b0;
        push(CODE_DOT, 16'd8);
        push(CODE_WORD, 16'd70);
        press(8);
        cyc(45);
        chk("stall_valid", 32'(out_valid), 1);
        chk("stall_code", 32'(out_code), 32'(CODE_DOT));
        chk("stall_len", 32'(out_len), 8);
        chk("stall_ovf", 32'(ovf), 1);
        out_ready = 1'b1;
        cyc(50);
        chk("ovf_sticky", 32'(ovf), 1);
        chk("stall_drained", q.size(), 0);
        ovf_clr = 1'b1;
        cyc(1);
        ovf_clr = 1'b0;
        chk("ovf_cleared", 32'(ovf), 0);

        key_raw = 1'b1;
        cyc(21);
        chk("midpress_len", 32'(dut.cnt), 15);
        rst_n = 1'b0;
        #2;
        chk("midrst_valid", 32'(out_valid), 0);
        chk("midrst_code", 32'(out_code), 0);
        chk("midrst_len", 32'(out_len), 0);
        key_raw = 1'b0;
        cyc(5);
        rst_n = 1'b1;
        cyc(100);
        chk("midrst_no_event", q.size(), 0);

        push(CODE_DOT, 16'd8);
        press(8);
        cyc(20);
        enable = 1'b0;
        cyc(100);
        enable = 1'b1;
        cyc(100);
        chk("enable_drained", q.size(), 0);

        eb.code = CODE_DASH;   eb.len = 16'd63; qb.push_back(eb);
        eb.code = CODE_LETTER; eb.len = 16'd30; qb.push_back(eb);
        eb.code = CODE_WORD;   eb.len = 16'd60; qb.push_back(eb);
        key_b = 1'b1;
        cyc(100);
        key_b = 1'b0;
        cyc(90);
        chk("sat_drained", qb.size(), 0);
        chk("final_q_empty", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
